// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared constants and helpers for the tick scheduler
// Default widths and ratios, plus the channel-index width used by the write port.
package tick_pkg;

  localparam int CW            = 32;
  localparam int DEFAULT_RATIO = 100000;

  // A single channel still needs a one-bit index so the port never collapses to zero width.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - ratio write port shared by the host and the scheduler
// The host drives the request fields; the scheduler answers with one-cycle ack/err pulses.
interface tick_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = tick_pkg::CW
);
  import tick_pkg::*;

  localparam int CHW = ch_w(NCH);

  logic           i_WR_EN;
  logic [CHW-1:0] i_WR_CH;
  logic [CW-1:0]  i_WR_RATIO;
  logic           o_WR_ACK;
  logic           o_WR_ERR;

  modport master (
    output i_WR_EN,
    output i_WR_CH,
    output i_WR_RATIO,
    input  o_WR_ACK,
    input  o_WR_ERR
  );

  modport slave (
    input  i_WR_EN,
    input  i_WR_CH,
    input  i_WR_RATIO,
    output o_WR_ACK,
    output o_WR_ERR
  );

endinterface

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one tick channel: period counter, shadow ratio and pending flag
// A written ratio waits in the shadow register until the next period boundary or a stop.
module tick_channel #(
  parameter int CW            = tick_pkg::CW,
  parameter int DEFAULT_RATIO = tick_pkg::DEFAULT_RATIO
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  input  logic          i_RUN,
  input  logic          i_WR,
  input  logic [CW-1:0] i_WR_RATIO,
  output logic          o_PEND,
  output logic          o_TICK,
  output logic          o_LVL
);
  import tick_pkg::*;

  logic [CW-1:0] r_ratio;
  logic [CW-1:0] r_shadow;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_tick;
  logic          r_lvl;
  logic          w_wrap;

  assign w_wrap = (r_cnt == (r_ratio - CW'(1)));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_ratio  <= CW'(DEFAULT_RATIO);
      r_shadow <= CW'(DEFAULT_RATIO);
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
      r_lvl    <= 1'b0;
    end else begin
      if (!i_RUN) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_lvl  <= 1'b0;
        if (r_pend) begin
          r_ratio <= r_shadow;
          r_pend  <= 1'b0;
        end
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        r_lvl  <= ~r_lvl;
        if (r_pend) begin
          r_ratio <= r_shadow;
          r_pend  <= 1'b0;
        end
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_tick <= 1'b0;
      end
      // A write on the boundary edge re-arms pend, so it lands at the following boundary.
      if (i_WR) begin
        r_shadow <= i_WR_RATIO;
        r_pend   <= 1'b1;
      end
    end
  end

  assign o_PEND = r_pend;
  assign o_TICK = r_tick;
  assign o_LVL  = r_lvl;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel tick generator with run-time ratio reprogramming
// Validates and routes ratio writes to the channels and registers the write response.
module tick_scheduler #(
  parameter int NCH           = 4,
  parameter int CW            = tick_pkg::CW,
  parameter int DEFAULT_RATIO = tick_pkg::DEFAULT_RATIO
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  input  logic [NCH-1:0]  i_RUN,
  tick_scheduler_if.slave wr,
  output logic [NCH-1:0]  o_PEND,
  output logic [NCH-1:0]  o_TICK,
  output logic [NCH-1:0]  o_LVL
);
  import tick_pkg::*;

  logic           w_ch_ok;
  logic           w_wr_ok;
  logic [NCH-1:0] w_wr_sel;
  logic           r_wr_ack;
  logic           r_wr_err;

  assign w_ch_ok = (int'(wr.i_WR_CH) < NCH);
  assign w_wr_ok = wr.i_WR_EN && (wr.i_WR_RATIO != '0) && w_ch_ok;

  always_comb begin
    w_wr_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_wr_ok && (int'(wr.i_WR_CH) == c)) begin
        w_wr_sel[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_ok;
      r_wr_err <= wr.i_WR_EN && !w_wr_ok;
    end
  end

  assign wr.o_WR_ACK = r_wr_ack;
  assign wr.o_WR_ERR = r_wr_err;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .CW            (CW),
      .DEFAULT_RATIO (DEFAULT_RATIO)
    ) u_ch (
      .i_CLK      (i_CLK),
      .i_RST_N    (i_RST_N),
      .i_RUN      (i_RUN[g]),
      .i_WR       (w_wr_sel[g]),
      .i_WR_RATIO (wr.i_WR_RATIO),
      .o_PEND     (o_PEND[g]),
      .o_TICK     (o_TICK[g]),
      .o_LVL      (o_LVL[g])
    );
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel programmable tick generator and divider controller. It replaces free-running, fixed-ratio clock dividers with single-cycle enable pulses on the system clock. Each channel's division ratio is reprogrammed at run time through a shared write port, and a new ratio is applied only at a period boundary. Downstream timers, debouncers and display scanners consume `o_TICK` as a clock enable, or `o_LVL` where a square wave is required.

## Interface
Parameters:
- `NCH`, 4, number of independent channels (1..16)
- `CW`, 32, ratio and counter width in bits
- `DEFAULT_RATIO`, 100000, reset ratio for every channel (1 ms at 100 MHz)

Ports:
- `i_CLK`  in  1  system clock; all logic on the rising edge
- `i_RST_N`  in  1  reset; asynchronous assert, active-low
- `i_RUN`  in  NCH  per-channel run enable, level-sensitive
- `i_WR_EN`  in  1  ratio write strobe, sampled each edge
- `i_WR_CH`  in  max(1,$clog2(NCH))  target channel of the write
- `i_WR_RATIO`  in  CW  requested ratio, in cycles per tick
- `o_WR_ACK`  out  1  one-cycle pulse: write accepted
- `o_WR_ERR`  out  1  one-cycle pulse: write rejected
- `o_PEND`  out  NCH  channel holds a written but not yet applied ratio
- `o_TICK`  out  NCH  one-cycle enable pulse per period
- `o_LVL`  out  NCH  toggles on every tick, so its period is 2×ratio

## Operation
- Per-channel registers:
  - `ratio`, the active ratio
  - `shadow`, the written ratio
  - `pend`
  - `cnt` (CW bits)
  - `tick`
  - `lvl`
- Each channel has two states: STOP (i_RUN=0) and RUN (i_RUN=1). The transition is evaluated every edge.
- STOP:
  - cnt<=0, tick<=0.
  - lvl<=0.
  - Any pending ratio is applied immediately.
- RUN:
  - If cnt==ratio-1: cnt<=0, tick<=1, lvl<=~lvl. If pend is set, ratio<=shadow and pend<=0 (the wrap edge).
  - Otherwise: cnt<=cnt+1, tick<=0.
- Ratio 1 in RUN gives a tick on every cycle (cnt stays 0).
- A write is accepted when i_WR_EN=1, i_WR_RATIO!=0 and i_WR_CH<NCH:
  - shadow<=i_WR_RATIO and pend<=1. A write to a channel that is already pending overwrites shadow; last write wins.
  - o_WR_ACK<=1 on the same edge.
- A write with ratio 0 or an out-of-range channel is rejected: o_WR_ERR<=1 and no state changes.
- A write on the same edge as that channel's wrap is captured in shadow. It is applied at the next wrap, not the current one; the current wrap uses the old pending value, if any.
- A write to a STOP channel: shadow is loaded this edge and moved to ratio on the following edge.
- Counter comparison is unsigned and full-width. No saturation logic is needed because cnt never exceeds ratio-1.
- If i_RUN falls mid-period, the partial count is discarded and no tick is emitted. A restart begins a fresh full period.

## Timing
- Reset values:
  - o_TICK, o_LVL, o_PEND, o_WR_ACK, o_WR_ERR = 0
  - ratio and shadow = DEFAULT_RATIO
  - cnt = 0
- All outputs are registered, with no combinational input-to-output path.
- Start latency: if i_RUN is first sampled high at edge k, the first o_TICK is high after edge k+ratio-1. Subsequent ticks are exactly ratio cycles apart.
- Write response: o_WR_ACK or o_WR_ERR is high for exactly the cycle after the sampling edge. o_PEND rises on that same edge.
- A new ratio in RUN takes effect at the first wrap after acceptance. That wrap's tick still ends the old-length period; the next period has the new length.
- The write port never stalls; back-to-back writes on consecutive cycles are all accepted.
- Asynchronous reset mid-period clears everything immediately. Release is sampled synchronously and counting restarts per the start-latency rule.

## Structure
- Package `tick_pkg`: constants CW and DEFAULT_RATIO, plus the channel-index width function.
- Sub-module `tick_channel`: one channel's counter, shadow and pend logic, instantiated NCH times.
- The top level contains write decode, validation and the ack/err registers.

## Test plan
- Reset, then i_RUN[0]=1 with default ratio scaled by DEFAULT_RATIO=10 → first tick 10 edges after RUN, then every 10 cycles; o_LVL period 20.
- Write ch1 ratio 3 while ch1 is running at 10 mid-period → o_WR_ACK next cycle, o_PEND[1]=1 until the current 10-cycle period ends, then ticks every 3 cycles.
- Write ratio 0, then channel 5 with NCH=4 → o_WR_ERR pulses, no ACK, ratios unchanged.
- Write ratio 4 then ratio 6 to running ch2 before its wrap → the wrap applies 6; 4 is never used.
- Write coincident with a ch0 wrap edge (ratio 5) → the current wrap keeps the old ratio, and 5 applies at the following wrap.
- Drop i_RUN[3] mid-period, then re-raise it; separately, assert i_RST_N low mid-count → no tick emitted, full ratio before the next tick; reset clears all outputs immediately.
